// File: rtl/big_alu.sv
// Registered 16-function integer ALU: result appears one clock after a valid operand/opcode beat.
// Optional flag outputs (zero/carry/overflow) are compiled in with `define BIG_ALU_FLAGS_EN.
module big_alu #(
  parameter int WIDTH = 4
) (
  input  logic             i_w_clk,
  input  logic             i_w_rst_n,
  input  logic             i_w_valid,
  input  logic [WIDTH-1:0] i_w_op1,
  input  logic [WIDTH-1:0] i_w_op2,
  input  logic [3:0]       i_w_sel,
`ifdef BIG_ALU_FLAGS_EN
  output logic             o_w_zero,
  output logic             o_w_carry,
  output logic             o_w_ovf,
`endif
  output logic [WIDTH-1:0] o_w_out,
  output logic             o_w_valid
);

  localparam int LW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NAND = 4'd5;
  localparam logic [3:0] OP_NOR  = 4'd6;
  localparam logic [3:0] OP_XNOR = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_ROL  = 4'd11;
  localparam logic [3:0] OP_ROR  = 4'd12;
  localparam logic [3:0] OP_MUL  = 4'd13;
  localparam logic [3:0] OP_MIN  = 4'd14;

  logic             sh_big;
  logic [LW-1:0]    rot;
  logic [LW:0]      rot_inv;
  logic [WIDTH-1:0] res;

  // Shifts saturate once the amount reaches WIDTH; rotates only use the low log2(WIDTH) bits.
  // rot_inv = WIDTH - rot; when rot is 0 the complementary shift by WIDTH yields 0.
  assign sh_big  = i_w_op2 >= WIDTH'(WIDTH);
  assign rot     = i_w_op2[LW-1:0];
  assign rot_inv = (LW+1)'(WIDTH) - {1'b0, rot};

`ifdef BIG_ALU_FLAGS_EN
  logic [WIDTH:0] sum_x;
  logic [WIDTH:0] diff_x;
  logic           carry_n;
  logic           ovf_n;

  assign sum_x  = {1'b0, i_w_op1} + {1'b0, i_w_op2};
  assign diff_x = {1'b0, i_w_op1} - {1'b0, i_w_op2};

  always_comb begin
    carry_n = 1'b0;
    ovf_n   = 1'b0;
    if (i_w_sel == OP_ADD) begin
      carry_n = sum_x[WIDTH];
      ovf_n   = (i_w_op1[WIDTH-1] == i_w_op2[WIDTH-1]) &&
                (sum_x[WIDTH-1] != i_w_op1[WIDTH-1]);
    end else if (i_w_sel == OP_SUB) begin
      carry_n = diff_x[WIDTH];
      ovf_n   = (i_w_op1[WIDTH-1] != i_w_op2[WIDTH-1]) &&
                (diff_x[WIDTH-1] != i_w_op1[WIDTH-1]);
    end
  end
`endif

  always_comb begin
    res = '0;
    case (i_w_sel)
      OP_ADD:  res = i_w_op1 + i_w_op2;
      OP_SUB:  res = i_w_op1 - i_w_op2;
      OP_AND:  res = i_w_op1 & i_w_op2;
      OP_OR:   res = i_w_op1 | i_w_op2;
      OP_XOR:  res = i_w_op1 ^ i_w_op2;
      OP_NAND: res = ~(i_w_op1 & i_w_op2);
      OP_NOR:  res = ~(i_w_op1 | i_w_op2);
      OP_XNOR: res = ~(i_w_op1 ^ i_w_op2);
      OP_SHL:  res = sh_big ? '0 : (i_w_op1 << i_w_op2);
      OP_SHR:  res = sh_big ? '0 : (i_w_op1 >> i_w_op2);
      OP_SRA:  res = sh_big ? {WIDTH{i_w_op1[WIDTH-1]}}
                            : WIDTH'($signed(i_w_op1) >>> i_w_op2);
      OP_ROL:  res = (i_w_op1 << rot) | (i_w_op1 >> rot_inv);
      OP_ROR:  res = (i_w_op1 >> rot) | (i_w_op1 << rot_inv);
      OP_MUL:  res = i_w_op1 * i_w_op2;
      OP_MIN:  res = (i_w_op1 < i_w_op2) ? i_w_op1 : i_w_op2;
      default: res = (i_w_op1 > i_w_op2) ? i_w_op1 : i_w_op2;
    endcase
  end

  always_ff @(posedge i_w_clk) begin
    if (!i_w_rst_n) begin
      o_w_out   <= '0;
      o_w_valid <= 1'b0;
`ifdef BIG_ALU_FLAGS_EN
      o_w_zero  <= 1'b0;
      o_w_carry <= 1'b0;
      o_w_ovf   <= 1'b0;
`endif
    end else begin
      o_w_valid <= i_w_valid;
      if (i_w_valid) begin
        o_w_out   <= res;
`ifdef BIG_ALU_FLAGS_EN
        o_w_zero  <= (res == '0);
        o_w_carry <= carry_n;
        o_w_ovf   <= ovf_n;
`endif
      end
    end
  end

endmodule

// File: tb/tb_big_alu.sv
// Self-checking bench for big_alu (WIDTH=4): directed vectors with literal results, then random traffic
// compared every cycle against an arithmetic reference model.
module tb_big_alu;
  localparam int W = 4;
  localparam int M = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         vin;
  logic [W-1:0] op1, op2;
  logic [3:0]   sel;
  logic [W-1:0] out;
  logic         vout;
`ifdef BIG_ALU_FLAGS_EN
  logic zf, cf, of;
  int   ez, ec, eo_f;
`endif

  int checks = 0;
  int passed = 0;
  int eo = 0;
  int ev = 0;

  always #5 clk = ~clk;

  big_alu #(.WIDTH(W)) dut (
    .i_w_clk  (clk),
    .i_w_rst_n(rst_n),
    .i_w_valid(vin),
    .i_w_op1  (op1),
    .i_w_op2  (op2),
    .i_w_sel  (sel),
`ifdef BIG_ALU_FLAGS_EN
    .o_w_zero (zf),
    .o_w_carry(cf),
    .o_w_ovf  (of),
`endif
    .o_w_out  (out),
    .o_w_valid(vout)
  );

  function automatic int sgn(input int x);
    return (x >= (1 << (W-1))) ? x - (1 << W) : x;
  endfunction

  function automatic int model(input int a, input int b, input int s);
    int r;
    r = 0;
    case (s)
      0:  r = a + b;
      1:  r = a - b;
      2:  r = a & b;
      3:  r = a | b;
      4:  r = a ^ b;
      5:  r = ~(a & b);
      6:  r = ~(a | b);
      7:  r = ~(a ^ b);
      8:  r = (b >= W) ? 0 : (a << b);
      9:  r = (b >= W) ? 0 : (a >> b);
      10: r = (b >= W) ? ((sgn(a) < 0) ? -1 : 0) : (sgn(a) >>> b);
      11: begin r = a; repeat (b % W) r = ((r << 1) | (r >> (W-1))) & M; end
      12: begin r = a; repeat (b % W) r = (r >> 1) | ((r & 1) << (W-1)); end
      13: r = a * b;
      14: r = (a < b) ? a : b;
      default: r = (a > b) ? a : b;
    endcase
    return r & M;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // One clock: drive, advance the model at the edge, compare just after it.
  task automatic cyc(input logic r, input logic v, input int s, input int a, input int b,
                     input int lit = -1);
    rst_n = r; vin = v; sel = 4'(s); op1 = W'(a); op2 = W'(b);
    @(posedge clk);
    if (!r) begin
      eo = 0; ev = 0;
`ifdef BIG_ALU_FLAGS_EN
      ez = 0; ec = 0; eo_f = 0;
`endif
    end else begin
      ev = v ? 1 : 0;
      if (v) begin
        eo = model(a, b, s);
`ifdef BIG_ALU_FLAGS_EN
        ez = (eo == 0) ? 1 : 0;
        ec = (s == 0) ? ((a + b > M) ? 1 : 0) : (s == 1) ? ((a < b) ? 1 : 0) : 0;
        eo_f = 0;
        if (s == 0 || s == 1) begin
          int t;
          t = (s == 0) ? sgn(a) + sgn(b) : sgn(a) - sgn(b);
          eo_f = (t > (1 << (W-1)) - 1 || t < -(1 << (W-1))) ? 1 : 0;
        end
`endif
      end
    end
    #1;
    chk("out", 32'(out), 32'(eo));
    chk("valid", 32'(vout), 32'(ev));
`ifdef BIG_ALU_FLAGS_EN
    chk("zero", 32'(zf), 32'(ez));
    chk("carry", 32'(cf), 32'(ec));
    chk("ovf", 32'(of), 32'(eo_f));
`endif
    if (lit >= 0) chk("literal", 32'(out), 32'(lit));
  endtask

  initial begin
    int logic_exp [6] = '{8, 14, 6, 7, 1, 9};
    rst_n = 1'b0; vin = 1'b0; sel = '0; op1 = '0; op2 = '0;

    // Pin the model itself against hand-computed values.
    chk("model_add", 32'(model(9, 8, 0)), 32'h1);
    chk("model_sra", 32'(model(8, 6, 10)), 32'hF);
    chk("model_ror", 32'(model(9, 5, 12)), 32'hC);
    chk("model_rol", 32'(model(9, 1, 11)), 32'h3);

    cyc(0, 1, 0, 15, 15, 0);
    cyc(0, 1, 0, 15, 15, 0);
    chk("rst_valid", 32'(vout), 32'h0);
    cyc(1, 1, 0, 15, 15, 14);
    chk("rel_valid", 32'(vout), 32'h1);

    cyc(1, 1, 0, 9, 8, 1);
`ifdef BIG_ALU_FLAGS_EN
    chk("add_carry", 32'(cf), 32'h1);
    chk("add_ovf", 32'(of), 32'h1);
`endif
    cyc(1, 1, 1, 3, 5, 14);
`ifdef BIG_ALU_FLAGS_EN
    chk("sub_borrow", 32'(cf), 32'h1);
`endif
    cyc(1, 1, 13, 7, 3, 5);
    for (int s = 2; s <= 7; s++) cyc(1, 1, s, 12, 10, logic_exp[s-2]);

    cyc(1, 1, 10, 8, 1, 12);
    cyc(1, 1, 10, 8, 6, 15);
    cyc(1, 1, 8, 3, 4, 0);
    cyc(1, 1, 11, 9, 1, 3);
    cyc(1, 1, 12, 9, 5, 12);

    cyc(1, 1, 4, 12, 10, 6);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, i, 15 - i, i + 1, 6);
      chk("hold_valid", 32'(vout), 32'h0);
    end
    cyc(1, 1, 14, 4, 11, 4);
    cyc(1, 1, 15, 4, 11, 11);

    cyc(1, 1, 0, 2, 3, 5);
    cyc(0, 1, 0, 4, 4, 0);
    chk("midrst_valid", 32'(vout), 32'h0);
    cyc(1, 1, 0, 6, 1, 7);

    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0),
          int'($urandom_range(0, 15)), int'($urandom_range(0, M)), int'($urandom_range(0, M)));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
